bf16_mul_issue: RTL and testbench
=================================

Name: bf16_mul_issue

Overview:
Sequential issue/collect stage that sits directly around the combinational bfloat16 multiplier.
- Buffers incoming operand pairs in a small synchronous FIFO.
- Drives the FIFO head onto the multiplier operand inputs.
- Captures the multiplier product into an output register with a valid/ready handshake.
- Turns the purely combinational multiplier into a back-pressurable streaming unit for the datapath.

Parameters:
DEPTH, 4, operand FIFO entries (power of two, >=2)
CNT_W, 16, width of optional statistics counters

Ports:
clk  input  1  single system clock, rising edge
rstn  input  1  reset, synchronous, active-low
in_flush  input  1  synchronous flush of FIFO and output register
in_valid  input  1  operand pair valid
in_ready  output  1  stage can accept a pair this cycle
in_A  input  16  bfloat16 operand A
in_B  input  16  bfloat16 operand B
mul_A  output  16  operand A to multiplier (FIFO head)
mul_B  output  16  operand B to multiplier (FIFO head)
mul_result  input  16  combinational product returned by multiplier
out_valid  output  1  out_result holds a product
out_ready  input  1  consumer accepts out_result
out_result  output  16  registered bfloat16 product
out_issue_cnt  output  CNT_W  products delivered (STATS only)
out_special_cnt  output  CNT_W  delivered products with exponent 8'hFF or 8'h00 (STATS only)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rstn, sampled at the rising edge of clk.
- Reset values:
  - FIFO count and pointers = 0.
  - out_valid = 0, out_result = 16'h0000.
  - Counters = 0.
  - in_ready = 0 while rstn = 0.
- Push: occurs when in_valid && in_ready.
  - in_ready = (count != DEPTH) && !in_flush.
  - No push while full, even if a pop happens in the same cycle.
- Head: mul_A/mul_B = FIFO head entry. When empty, they hold the last head value; their value is don't-care.
- Pop/capture condition: count != 0 && (!out_valid || out_ready). On this condition:
  - out_result <= mul_result; out_valid <= 1; FIFO pops.
- Output release:
  - If out_valid && out_ready and no capture that cycle: out_valid <= 0; out_result holds.
  - Simultaneous accept and capture: out_valid stays 1 and out_result is replaced (full throughput, 1 product/cycle).
- Stall: out_result and out_valid are held stable while out_valid && !out_ready.
- Simultaneous push and pop: count unchanged; pointers each advance with modulo-DEPTH wrap.
- Latency: a pair accepted at edge t appears on out_result/out_valid after edge t+1, i.e. 2 cycles minimum. No empty-FIFO bypass.
- Flush (in_flush = 1 at edge): count, pointers and out_valid <= 0. Any push or capture that cycle is discarded. Flush overrides everything except reset.
- Reset mid-stream: all in-flight pairs and the held product are lost. No output after reset until new pairs are pushed.
- Arithmetic: no arithmetic in this block. Products and special encodings from the multiplier pass through unmodified.

Optional Feature:
BF16_MUL_ISSUE_STATS_EN
- Defined:
  - out_issue_cnt increments on each out_valid && out_ready.
  - out_special_cnt increments on the same event when out_result[14:7] is 8'hFF or 8'h00.
  - Both counters saturate at all-ones.
  - Both are cleared by reset, not by flush.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- Package bf16_pkg:
  - BF16_W = 16, EXP_W = 8, MANT_W = 7, EXP_ALL_ONES = 8'hFF, EXP_ZERO = 8'h00.
  - bf16 field-extract functions: sign, exp, mant.
  - is_special(exp) function.
- Sub-module bf16_sync_fifo:
  - Parameters: DEPTH and WIDTH = 32.
  - Interface: push/pop/flush, count, head data.
- Top-level logic is limited to the output register, handshake and stats.

Test Plan:
- Push 16'h3F80/16'h4000 (1.0×2.0) with out_ready = 1. Expect out_result = 16'h4000 and out_valid = 1 exactly 2 cycles after acceptance.
- Back-to-back push of 8 pairs, including 16'h3FC0×16'h4000, with out_ready = 1. Expect one product per cycle in order; 1.5×2.0 gives 16'h4040.
- Hold out_ready = 0 and push continuously. Expect in_ready to drop after DEPTH+1 accepted pairs (DEPTH in FIFO plus 1 in the output register) and out_result to stay stable. Release out_ready and expect in-order drain with no loss.
- Assert in_flush while 3 entries are queued and out_valid = 1 with in_valid = 1. Expect out_valid = 0, count = 0 and the pushed pair dropped next cycle.
- Assert rstn = 0 mid-stream. Expect out_valid = 0, out_result = 16'h0000 and in_ready = 0 during reset, then in_ready = 1 after release.
- With STATS enabled, deliver 16'h0000×16'h3F80 (result 16'h0000) and 16'h7F80×16'h3F80 (result 16'h7F80) plus 2 normal products. Expect out_issue_cnt = 4 and out_special_cnt = 2.

Source files
------------

// File: rtl/bf16_pkg.sv
// bfloat16 field definitions and helpers shared by the issue stage and its testbench.
package bf16_pkg;

    localparam int         BF16_W       = 16;
    localparam int         EXP_W        = 8;
    localparam int         MANT_W       = 7;
    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;
    localparam logic [7:0] EXP_ZERO     = 8'h00;

    typedef logic [BF16_W-1:0] bf16_t;

    typedef struct packed {
        bf16_t a;
        bf16_t b;
    } bf16_pair_t;

    function automatic logic bf16_sign(input bf16_t v);
        return v[BF16_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] bf16_exp(input bf16_t v);
        return v[BF16_W-2 -: EXP_W];
    endfunction

    function automatic logic [MANT_W-1:0] bf16_mant(input bf16_t v);
        return v[MANT_W-1:0];
    endfunction

    // Zero/subnormal and inf/NaN share the two reserved exponent encodings.
    function automatic logic is_special(input logic [EXP_W-1:0] e);
        return (e == EXP_ALL_ONES) || (e == EXP_ZERO);
    endfunction

endpackage

// File: rtl/bf16_mul_issue_if.sv
// Streaming bundle of the issue stage: operand input, multiplier loop and product output.
interface bf16_mul_issue_if;
    import bf16_pkg::*;

    logic  in_flush;
    logic  in_valid;
    logic  in_ready;
    bf16_t in_A;
    bf16_t in_B;
    bf16_t mul_A;
    bf16_t mul_B;
    bf16_t mul_result;
    logic  out_valid;
    logic  out_ready;
    bf16_t out_result;

    modport slave (
        input  in_flush, in_valid, in_A, in_B, mul_result, out_ready,
        output in_ready, mul_A, mul_B, out_valid, out_result
    );

    modport master (
        output in_flush, in_valid, in_A, in_B, mul_result, out_ready,
        input  in_ready, mul_A, mul_B, out_valid, out_result
    );

endinterface

// File: rtl/bf16_sync_fifo.sv
// Synchronous FIFO with flush; callers only push when not full and pop when not empty.
module bf16_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_BITS = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [WIDTH-1:0]    din,
    output logic [CNT_BITS-1:0] count,
    output logic [WIDTH-1:0]    head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/bf16_mul_issue.sv
// Issue/collect stage around the combinational bf16 multiplier: operand FIFO, output register, handshake.
// Optional delivery statistics are enabled by defining BF16_MUL_ISSUE_STATS_EN.
module bf16_mul_issue
    import bf16_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    bf16_mul_issue_if.slave  bus,
    output logic [CNT_W-1:0] out_issue_cnt,
    output logic [CNT_W-1:0] out_special_cnt
);

    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = PTR_W + 1;

    logic [CNT_BITS-1:0] count;
    bf16_pair_t          pair_in;
    bf16_pair_t          head;
    logic                push;
    logic                capture;
    logic                accept;
    bf16_t               res_p1;
    logic                vld_p1;

    assign pair_in      = {bus.in_A, bus.in_B};
    assign bus.in_ready = rstn && !bus.in_flush && (count != CNT_BITS'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign capture      = (count != '0) && (!vld_p1 || bus.out_ready);
    assign accept       = vld_p1 && bus.out_ready;

    bf16_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(bf16_pair_t))
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (capture),
        .flush (bus.in_flush),
        .din   (pair_in),
        .count (count),
        .head  (head)
    );

    assign bus.mul_A = head.a;
    assign bus.mul_B = head.b;

    // Stage p1: product register, refilled on the same edge it is accepted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
            res_p1 <= '0;
        end else if (bus.in_flush) begin
            vld_p1 <= 1'b0;
        end else if (capture) begin
            vld_p1 <= 1'b1;
            res_p1 <= bus.mul_result;
        end else if (accept) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid  = vld_p1;
    assign bus.out_result = res_p1;

`ifdef BF16_MUL_ISSUE_STATS_EN
    logic [CNT_W-1:0] issue_q;
    logic [CNT_W-1:0] special_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            issue_q   <= '0;
            special_q <= '0;
        end else if (accept) begin
            if (issue_q != '1) issue_q <= issue_q + 1'b1;
            if (is_special(bf16_exp(res_p1)) && (special_q != '1))
                special_q <= special_q + 1'b1;
        end
    end

    assign out_issue_cnt   = issue_q;
    assign out_special_cnt = special_q;
`else
    assign out_issue_cnt   = '0;
    assign out_special_cnt = '0;
`endif

endmodule

// File: tb/tb_bf16_mul_issue.sv
// Scoreboard bench for bf16_mul_issue with a behavioural bf16 multiplier closing the mul loop.
module tb_bf16_mul_issue;
    import bf16_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] special_cnt;

    bf16_mul_issue_if bus();

    bf16_mul_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .bus             (bus),
        .out_issue_cnt   (issue_cnt),
        .out_special_cnt (special_cnt)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    acc    = 0;
    int    pops   = 0;
    bf16_t q[$];

    // Truncating bf16 product from real-number rules: sign xor, exponent add, 8x8 significand multiply.
    function automatic bf16_t bf16_mul(input bf16_t a, input bf16_t b);
        logic        s;
        int          ea, eb, e;
        logic [15:0] m;
        s  = a[15] ^ b[15];
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        if (ea == 255 || eb == 255) return {s, 8'hFF, 7'h00};
        if (ea == 0 || eb == 0)     return {s, 15'h0000};
        m = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
        e = ea + eb - 127;
        if (m[15]) begin
            e = e + 1;
            m = m >> 8;
        end else begin
            m = m >> 7;
        end
        if (e >= 255) return {s, 8'hFF, 7'h00};
        if (e <= 0)   return {s, 15'h0000};
        return {s, e[7:0], m[6:0]};
    endfunction

    always_comb bus.mul_result = bf16_mul(bus.mul_A, bus.mul_B);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bf16_t rand_bf16();
        bf16_t specials [6] = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h0001};
        if ($urandom_range(0, 9) == 0) return specials[$urandom_range(0, 5)];
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 7'($urandom_range(0, 127))};
    endfunction

    task automatic drive(input logic v, input bf16_t a, input bf16_t b, input logic rdy, input logic fl);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_A      = a;
        bus.in_B      = b;
        bus.out_ready = rdy;
        bus.in_flush  = fl;
        #1;
        if (rstn && bus.in_valid && bus.in_ready) begin
            q.push_back(bf16_mul(a, b));
            acc++;
        end
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 16'h0000, 16'h0000, rdy, 1'b0);
    endtask

    // Monitor: compares every delivered product and the stall-hold rule.
    logic  prev_stall = 1'b0;
    bf16_t prev_res;
    always @(negedge clk) begin
        #2;
        if (prev_stall) begin
            chk("stall_valid", 16'(bus.out_valid), 16'h0001);
            chk("stall_result", bus.out_result, prev_res);
        end
        if (rstn === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            pops++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h expected=none", bus.out_result);
            end else begin
                chk("product", bus.out_result, q.pop_front());
            end
        end
        prev_stall = (rstn === 1'b1) && (bus.in_flush === 1'b0) &&
                     (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        prev_res   = bus.out_result;
        if (rstn !== 1'b1 || bus.in_flush === 1'b1) q.delete();
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int a0, p0, n;
        bf16_t seq_a [8] = '{16'h3F80, 16'h3FC0, 16'h4040, 16'hBF80, 16'h4100, 16'h3F00, 16'h0000, 16'h7F80};
        bf16_t seq_b [8] = '{16'h4000, 16'h4000, 16'h3FC0, 16'h4080, 16'hC000, 16'h3E80, 16'h4000, 16'h3F80};

        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_A      = '0;
        bus.in_B      = '0;
        bus.out_ready = 1'b0;
        bus.in_flush  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", 16'(bus.out_valid), 16'h0000);
        chk("reset_out_result", bus.out_result, 16'h0000);
        chk("reset_in_ready", 16'(bus.in_ready), 16'h0000);
        chk("reset_issue_cnt", issue_cnt, 16'h0000);
        chk("reset_special_cnt", special_cnt, 16'h0000);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post_reset_in_ready", 16'(bus.in_ready), 16'h0001);

        // Latency: accept at edge t, product visible only after edge t+1.
        drive(1'b1, 16'h3F80, 16'h4000, 1'b1, 1'b0);
        idle(1'b1);
        chk("lat_t1_valid", 16'(bus.out_valid), 16'h0000);
        idle(1'b1);
        chk("lat_t2_valid", 16'(bus.out_valid), 16'h0001);
        chk("lat_t2_result", bus.out_result, 16'h4000);
        repeat (2) idle(1'b1);

        // Back-to-back stream: full throughput, 1.5 x 2.0 = 16'h4040.
        a0 = acc;
        p0 = pops;
        for (int i = 0; i < 8; i++) drive(1'b1, seq_a[i], seq_b[i], 1'b1, 1'b0);
        chk("b2b_accepted", 16'(acc - a0), 16'd8);
        repeat (3) idle(1'b1);
        chk("b2b_delivered", 16'(pops - p0), 16'd8);
        chk("known_1p5x2", bf16_mul(16'h3FC0, 16'h4000), 16'h4040);

        // Backpressure: DEPTH in FIFO plus one held in the output register.
        a0 = acc;
        for (int i = 0; i < 10; i++) drive(1'b1, rand_bf16(), rand_bf16(), 1'b0, 1'b0);
        chk("bp_accepted", 16'(acc - a0), 16'(DEPTH + 1));
        chk("bp_in_ready", 16'(bus.in_ready), 16'h0000);
        p0 = pops;
        for (int i = 0; i < 10; i++) idle(1'b1);
        chk("bp_drained", 16'(pops - p0), 16'(DEPTH + 1));
        chk("bp_queue_empty", 16'(q.size()), 16'h0000);

        // Flush with three queued, one held, and a concurrent push attempt.
        for (int i = 0; i < 4; i++) drive(1'b1, rand_bf16(), rand_bf16(), 1'b0, 1'b0);
        chk("pre_flush_valid", 16'(bus.out_valid), 16'h0001);
        a0 = acc;
        drive(1'b1, 16'h3F80, 16'h3F80, 1'b0, 1'b1);
        chk("flush_push_dropped", 16'(acc - a0), 16'h0000);
        idle(1'b1);
        chk("flush_out_valid", 16'(bus.out_valid), 16'h0000);
        chk("flush_in_ready", 16'(bus.in_ready), 16'h0001);
        p0 = pops;
        drive(1'b1, 16'h4000, 16'h4000, 1'b1, 1'b0);
        repeat (4) idle(1'b1);
        chk("post_flush_delivered", 16'(pops - p0), 16'h0001);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 9) < 7), rand_bf16(), rand_bf16(),
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 49) == 0));
        n = 0;
        while (q.size() != 0 && n < 50) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        chk("random_drained", 16'(q.size()), 16'h0000);

        // Reset mid-stream drops everything in flight.
        for (int i = 0; i < 3; i++) drive(1'b1, rand_bf16(), rand_bf16(), 1'b0, 1'b0);
        @(negedge clk);
        rstn          = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", 16'(bus.in_ready), 16'h0000);
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 16'(bus.out_valid), 16'h0000);
        chk("midrst_out_result", bus.out_result, 16'h0000);
        chk("midrst_issue_cnt", issue_cnt, 16'h0000);
        @(negedge clk);
        rstn         = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("midrst_release_in_ready", 16'(bus.in_ready), 16'h0001);
        p0 = pops;
        repeat (4) idle(1'b1);
        chk("midrst_no_output", 16'(pops - p0), 16'h0000);

        // Statistics: two special products (zero, infinity) among four deliveries.
        drive(1'b1, 16'h0000, 16'h3F80, 1'b1, 1'b0);
        drive(1'b1, 16'h7F80, 16'h3F80, 1'b1, 1'b0);
        drive(1'b1, 16'h3F80, 16'h4000, 1'b1, 1'b0);
        drive(1'b1, 16'h3FC0, 16'h4000, 1'b1, 1'b0);
        repeat (4) idle(1'b1);
`ifdef BF16_MUL_ISSUE_STATS_EN
        chk("issue_cnt", issue_cnt, 16'd4);
        chk("special_cnt", special_cnt, 16'd2);
`else
        chk("issue_cnt_tied", issue_cnt, 16'd0);
        chk("special_cnt_tied", special_cnt, 16'd0);
`endif
        chk("final_queue_empty", 16'(q.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
